// File: rtl/upsp_pkg.sv
// Shared constants and width helpers for the upsample response merger.
package upsp_pkg;
    localparam int SUBPIX = 4;
    localparam int MAX_CH = 4;

    function automatic int beat_width(input int nch, input int cw);
        return SUBPIX * nch * cw;
    endfunction
endpackage

// File: rtl/upsp_ch_fifo.sv
// Per-channel response FIFO; pointers carry an extra wrap bit for full/empty.
module upsp_ch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + ONE;
            if (pop && !empty) rp <= rp + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/upsp_rsp_merger.sv
// Joins per-channel upsample responses into one registered write beat
// with line/frame tracking and a sticky channel-skew flag.
module upsp_rsp_merger
    import upsp_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int CHANNEL_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     ch_rsp_valid,
    output logic [NUM_CH-1:0]                     ch_rsp_ready,
    input  logic [NUM_CH*SUBPIX*CHANNEL_WIDTH-1:0] ch_rsp_data,
    input  logic [CNT_WIDTH-1:0]                  cfg_line_beats,
    input  logic [CNT_WIDTH-1:0]                  cfg_frame_lines,
    output logic                                  upsp_ac_wvalid,
    input  logic                                  ac_upsp_wready,
    output logic [SUBPIX*NUM_CH*CHANNEL_WIDTH-1:0] upsp_ac_wdata,
    output logic                                  upsp_ac_wlast,
    output logic                                  frame_done,
    output logic                                  ch_skew_err
);
    localparam int SW = SUBPIX * CHANNEL_WIDTH;
    localparam int OW = beat_width(NUM_CH, CHANNEL_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    push;
    logic [SW-1:0]        head [NUM_CH];
    logic [OW-1:0]        wdata_d;
    logic                 all_avail;
    logic                 load;
    logic                 hs;
    logic                 last_d;
    logic                 frame_end;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] beat_nxt;
    logic [CNT_WIDTH-1:0] line_cnt;

    // Ready depends only on full so the upstream path stays register-driven.
    assign ch_rsp_ready = ~full;
    assign push         = ch_rsp_valid & ~full;
    assign all_avail    = ~|empty;
    assign hs           = upsp_ac_wvalid & ac_upsp_wready;
    assign load         = all_avail & (!upsp_ac_wvalid | ac_upsp_wready);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        upsp_ch_fifo #(
            .WIDTH(SW),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[c]),
            .din  (ch_rsp_data[c*SW +: SW]),
            .pop  (load),
            .dout (head[c]),
            .full (full[c]),
            .empty(empty[c])
        );

        // Subpixel-major packing with channel 0 most significant in each group.
        for (genvar k = 0; k < SUBPIX; k++) begin : g_sub
            assign wdata_d[((SUBPIX-1-k)*NUM_CH + (NUM_CH-1-c))*CHANNEL_WIDTH
                           +: CHANNEL_WIDTH] =
                head[c][(SUBPIX-1-k)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
    end

    always_comb begin
        beat_nxt = beat_cnt;
        if (hs) beat_nxt = upsp_ac_wlast ? '0 : beat_cnt + ONE;
        last_d    = (cfg_line_beats != '0) && (beat_nxt == cfg_line_beats - ONE);
        frame_end = hs && upsp_ac_wlast && (cfg_frame_lines != '0) &&
                    (line_cnt == cfg_frame_lines - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upsp_ac_wvalid <= 1'b0;
            upsp_ac_wdata  <= '0;
            upsp_ac_wlast  <= 1'b0;
            frame_done     <= 1'b0;
            ch_skew_err    <= 1'b0;
            beat_cnt       <= '0;
            line_cnt       <= '0;
        end else begin
            beat_cnt   <= beat_nxt;
            frame_done <= frame_end;
            if (hs && upsp_ac_wlast) line_cnt <= frame_end ? '0 : line_cnt + ONE;
            if (load) begin
                upsp_ac_wvalid <= 1'b1;
                upsp_ac_wdata  <= wdata_d;
                upsp_ac_wlast  <= last_d;
            end else if (hs) begin
                upsp_ac_wvalid <= 1'b0;
            end
            ch_skew_err <= ch_skew_err | ((|full) & (|empty));
        end
    end
endmodule

// File: tb/tb_upsp_rsp_merger.sv
// Randomised and directed bench for upsp_rsp_merger against a queue-based model.
module tb_upsp_rsp_merger;
    localparam int NUM_CH = 3;
    localparam int CW     = 8;
    localparam int DEPTH  = 4;
    localparam int SW     = 4 * CW;
    localparam int OW     = 4 * NUM_CH * CW;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH*SW-1:0] data;
    logic [15:0]       cfg_l;
    logic [15:0]       cfg_f;
    logic              wvalid;
    logic              wready;
    logic [OW-1:0]     wdata;
    logic              wlast;
    logic              fdone;
    logic              skew;

    upsp_rsp_merger #(
        .NUM_CH(NUM_CH), .CHANNEL_WIDTH(CW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_rsp_valid(valid), .ch_rsp_ready(ready), .ch_rsp_data(data),
        .cfg_line_beats(cfg_l), .cfg_frame_lines(cfg_f),
        .upsp_ac_wvalid(wvalid), .ac_upsp_wready(wready),
        .upsp_ac_wdata(wdata), .upsp_ac_wlast(wlast),
        .frame_done(fdone), .ch_skew_err(skew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] mq [NUM_CH][$];
    bit            m_valid;
    bit            m_last;
    bit            m_fd;
    bit            m_skew;
    logic [OW-1:0] m_data;
    int            loaded;
    int            m_num;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] pack_model();
        logic [OW-1:0] r = '0;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < NUM_CH; c++)
                r = (r << CW) | OW'((mq[c][0] >> (CW * (3 - k))) & 8'hff);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_valid = 0; m_last = 0; m_fd = 0; m_skew = 0;
        m_data = '0; loaded = 0; m_num = 0;
    endtask

    task automatic model_edge();
        bit hs, all, load, any_full, any_empty;
        bit rdy [NUM_CH];
        int lb, fl;
        lb = int'(cfg_l);
        fl = int'(cfg_f);
        hs = m_valid && wready;
        all = 1; any_full = 0; any_empty = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            rdy[c] = mq[c].size() < DEPTH;
            if (mq[c].size() == 0) begin all = 0; any_empty = 1; end
            if (mq[c].size() == DEPTH) any_full = 1;
        end
        load = all && (!m_valid || wready);
        m_fd = hs && lb != 0 && fl != 0 && (m_num % (lb * fl) == 0);
        if (hs) m_valid = 0;
        if (load) begin
            m_data = pack_model();
            for (int c = 0; c < NUM_CH; c++) void'(mq[c].pop_front());
            loaded++;
            m_num = loaded;
            m_last = lb != 0 && (loaded % lb == 0);
            m_valid = 1;
        end
        for (int c = 0; c < NUM_CH; c++)
            if (valid[c] && rdy[c]) mq[c].push_back(data[c*SW +: SW]);
        m_skew = m_skew || (any_full && any_empty);
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] er;
        for (int c = 0; c < NUM_CH; c++) er[c] = mq[c].size() < DEPTH;
        chk("wvalid", OW'(wvalid), OW'(m_valid));
        if (m_valid) begin
            chk("wdata", wdata, m_data);
            chk("wlast", OW'(wlast), OW'(m_last));
        end
        chk("frame_done", OW'(fdone), OW'(m_fd));
        chk("skew_err", OW'(skew), OW'(m_skew));
        chk("ready", OW'(ready), OW'(er));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) data[c*SW +: SW] = $urandom;
    endtask

    task automatic do_reset(input logic [15:0] l, input logic [15:0] f);
        rst_n = 1'b0;
        valid = '0;
        wready = 1'b0;
        cfg_l = l;
        cfg_f = f;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wvalid", OW'(wvalid), '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_flags", OW'({wlast, fdone, skew}), '0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '0;
        data = '0;
        wready = 1'b0;
        cfg_l = '0;
        cfg_f = '0;

        // Aligned stream with fixed per-channel pattern
        do_reset(16'd0, 16'd0);
        chk("rst_ready", OW'(ready), OW'(3'b111));
        for (int c = 0; c < NUM_CH; c++)
            data[c*SW +: SW] = 32'h11223344 + {4{8'(c)}};
        valid = '1;
        wready = 1'b1;
        step();
        chk("lat_first", OW'(wvalid), '0);
        step();
        chk("lat_second", OW'(wvalid), OW'(1'b1));
        chk("aligned_data", wdata, 96'h111213222324333435444546);
        repeat (4) step();

        // Line/frame tracking with random payloads
        do_reset(16'd4, 16'd2);
        valid = '1;
        wready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            step();
        end

        // Backpressure mid-stream
        wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
        end
        wready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step();
        end

        // Skewed start: ch2 joins three cycles late
        do_reset(16'd4, 16'd2);
        wready = 1'b1;
        valid = 3'b011;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
        end
        valid = 3'b111;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step();
        end
        chk("skew_ok", OW'(skew), '0);

        // Skew error: ch1 starved while ch0 fills
        valid = 3'b101;
        for (int i = 0; i < 7; i++) begin
            rand_data();
            step();
        end
        chk("skew_set", OW'(skew), OW'(1'b1));
        valid = 3'b111;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step();
        end

        // Random traffic
        do_reset(16'd3, 16'd3);
        for (int i = 0; i < 400; i++) begin
            valid = NUM_CH'($urandom);
            wready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        // Reset mid-burst with entries buffered
        do_reset(16'd4, 16'd2);
        valid = '1;
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_wvalid", OW'(wvalid), '0);
        chk("async_wdata", wdata, '0);
        model_clear();
        valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        valid = '1;
        wready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
